// File: rtl/rcu_prf_pkg.sv
// Shared constants and types for the RCU physical-regfile write path.
package rcu_prf_pkg;

    localparam int unsigned PRF_ADDR_WIDTH  = 6;
    localparam int unsigned PRF_DATA_WIDTH  = 64;
    localparam int unsigned PRF_WR_PORTS    = 2;
    localparam int unsigned PRF_WB_CHANNELS = 7;

    typedef struct packed {
        logic                      valid;
        logic [PRF_ADDR_WIDTH-1:0] addr;
        logic [PRF_DATA_WIDTH-1:0] data;
    } prf_wr_req_t;

endpackage

// File: rtl/prf_write_arbiter_if.sv
// Writeback request channels in, regfile write ports out.
interface prf_write_arbiter_if #(
    parameter int unsigned NUM_REQ        = 7,
    parameter int unsigned NUM_PORT       = 2,
    parameter int unsigned REG_ADDR_WIDTH = 6,
    parameter int unsigned REG_DATA_WIDTH = 64
);
    localparam int unsigned CNT_W = $clog2(NUM_REQ + 1);

    logic                                flush_i;
    logic [NUM_REQ-1:0]                  wr_valid_i;
    logic [NUM_REQ-1:0]                  wr_ready_o;
    logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   wr_addr_i;
    logic [NUM_REQ*REG_DATA_WIDTH-1:0]   wr_data_i;
    logic [NUM_PORT-1:0]                 port_valid_o;
    logic [NUM_PORT*REG_ADDR_WIDTH-1:0]  port_addr_o;
    logic [NUM_PORT*REG_DATA_WIDTH-1:0]  port_data_o;
    logic [CNT_W-1:0]                    pend_cnt_o;

    modport master (
        output flush_i, wr_valid_i, wr_addr_i, wr_data_i,
        input  wr_ready_o, port_valid_o, port_addr_o, port_data_o, pend_cnt_o
    );

    modport slave (
        input  flush_i, wr_valid_i, wr_addr_i, wr_data_i,
        output wr_ready_o, port_valid_o, port_addr_o, port_data_o, pend_cnt_o
    );

endinterface

// File: rtl/rr_multi_pick.sv
// Combinational round-robin picker: up to K grants from N requests, scanning
// cyclically from start_i. The k-th grant in scan order lands in sel_o[k].
module rr_multi_pick #(
    parameter int unsigned N = 7,
    parameter int unsigned K = 2,
    localparam int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]        req_i,
    input  logic [PTR_W-1:0]    start_i,
    output logic [N-1:0]        grant_o,
    output logic [K-1:0][N-1:0] sel_o,
    output logic [PTR_W-1:0]    last_o,
    output logic                any_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] cand;
    logic           found;
    int unsigned    idx;
    int unsigned    start_u;

    assign dbl = {req_i, req_i};

    always_comb begin
        start_u = 32'(start_i);
        cand    = '0;
        found   = 1'b0;
        idx     = 0;
        grant_o = '0;
        sel_o   = '0;
        last_o  = '0;
        any_o   = 1'b0;
        // Window of N positions starting at start_i covers each channel exactly once.
        for (int unsigned j = 0; j < 2 * N; j++) begin
            if (j >= start_u && j < start_u + N) begin
                cand[j] = dbl[j];
            end
        end
        for (int unsigned k = 0; k < K; k++) begin
            found = 1'b0;
            for (int unsigned j = 0; j < 2 * N; j++) begin
                if (!found && cand[j]) begin
                    found         = 1'b1;
                    cand[j]       = 1'b0;
                    idx           = (j >= N) ? j - N : j;
                    sel_o[k][idx] = 1'b1;
                    grant_o[idx]  = 1'b1;
                    last_o        = PTR_W'(idx);
                    any_o         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prf_write_arbiter.sv
// Physical-regfile write-port arbiter: one pending slot per writeback channel,
// round-robin mapping of pending entries onto registered write ports.
module prf_write_arbiter
    import rcu_prf_pkg::*;
#(
    parameter int unsigned NUM_REQ        = PRF_WB_CHANNELS,
    parameter int unsigned NUM_PORT       = PRF_WR_PORTS,
    parameter int unsigned REG_ADDR_WIDTH = PRF_ADDR_WIDTH,
    parameter int unsigned REG_DATA_WIDTH = PRF_DATA_WIDTH,
    localparam int unsigned PTR_W = $clog2(NUM_REQ),
    localparam int unsigned CNT_W = $clog2(NUM_REQ + 1)
) (
    input logic                clk,
    input logic                rstn,
    prf_write_arbiter_if.slave bus
);

    localparam int unsigned AW = REG_ADDR_WIDTH;
    localparam int unsigned DW = REG_DATA_WIDTH;

    logic [NUM_REQ-1:0]           pend_vld_q, pend_vld_d;
    logic [NUM_REQ-1:0][AW-1:0]   pend_addr_q, pend_addr_d;
    logic [NUM_REQ-1:0][DW-1:0]   pend_data_q, pend_data_d;
    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [NUM_PORT-1:0]          port_valid_q, port_valid_d;
    logic [NUM_PORT-1:0][AW-1:0]  port_addr_q, port_addr_d;
    logic [NUM_PORT-1:0][DW-1:0]  port_data_q, port_data_d;
    logic [CNT_W-1:0]             pend_cnt_q, pend_cnt_d;

    logic [NUM_REQ-1:0]               grant;
    logic [NUM_REQ-1:0]               ready;
    logic [NUM_REQ-1:0]               accept;
    logic [NUM_PORT-1:0][NUM_REQ-1:0] sel;
    logic [PTR_W-1:0]                 last_grant;
    logic                             any_grant;

    rr_multi_pick #(
        .N (NUM_REQ),
        .K (NUM_PORT)
    ) u_pick (
        .req_i   (pend_vld_q),
        .start_i (rr_ptr_q),
        .grant_o (grant),
        .sel_o   (sel),
        .last_o  (last_grant),
        .any_o   (any_grant)
    );

    // A slot draining this cycle can take a new request in the same cycle.
    assign ready  = {NUM_REQ{~bus.flush_i}} & (~pend_vld_q | grant);
    assign accept = bus.wr_valid_i & ready;

    always_comb begin
        pend_vld_d  = '0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (!bus.flush_i) begin
            pend_vld_d = (pend_vld_q & ~grant) | accept;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    pend_addr_d[i] = bus.wr_addr_i[i*AW +: AW];
                    pend_data_d[i] = bus.wr_data_i[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        port_valid_d = '0;
        port_addr_d  = '0;
        port_data_d  = '0;
        if (!bus.flush_i) begin
            for (int unsigned k = 0; k < NUM_PORT; k++) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (sel[k][i]) begin
                        port_valid_d[k] = 1'b1;
                        port_addr_d[k]  = pend_addr_q[i];
                        port_data_d[k]  = pend_data_q[i];
                    end
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!bus.flush_i && any_grant) begin
            rr_ptr_d = (last_grant == PTR_W'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;
        end
        pend_cnt_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pend_cnt_d = pend_cnt_d + CNT_W'(pend_vld_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_vld_q   <= '0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            rr_ptr_q     <= '0;
            port_valid_q <= '0;
            port_addr_q  <= '0;
            port_data_q  <= '0;
            pend_cnt_q   <= '0;
        end else begin
            pend_vld_q   <= pend_vld_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            rr_ptr_q     <= rr_ptr_d;
            port_valid_q <= port_valid_d;
            port_addr_q  <= port_addr_d;
            port_data_q  <= port_data_d;
            pend_cnt_q   <= pend_cnt_d;
        end
    end

    assign bus.wr_ready_o   = ready;
    assign bus.port_valid_o = port_valid_q;
    assign bus.port_addr_o  = port_addr_q;
    assign bus.port_data_o  = port_data_q;
    assign bus.pend_cnt_o   = pend_cnt_q;

endmodule

// File: tb/tb_prf_write_arbiter.sv
// Directed bench for prf_write_arbiter (7 channels, 2 ports).
module tb_prf_write_arbiter;
    import rcu_prf_pkg::*;

    localparam int unsigned NR = 7;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = PRF_ADDR_WIDTH;
    localparam int unsigned DW = PRF_DATA_WIDTH;
    localparam logic [NR-1:0] ALL1 = '1;

    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    prf_write_arbiter_if #(
        .NUM_REQ        (NR),
        .NUM_PORT       (NP),
        .REG_ADDR_WIDTH (AW),
        .REG_DATA_WIDTH (DW)
    ) bus ();

    prf_write_arbiter #(
        .NUM_REQ        (NR),
        .NUM_PORT       (NP),
        .REG_ADDR_WIDTH (AW),
        .REG_DATA_WIDTH (DW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Renaming guarantees distinct addresses on simultaneously valid ports.
    always @(negedge clk) begin
        if (rstn && bus.port_valid_o[0] && bus.port_valid_o[1] &&
            bus.port_addr_o[0 +: AW] == bus.port_addr_o[AW +: AW]) begin
            n_err++;
            $display("FAIL port_addr_conflict: got addr %0d on both ports, required distinct",
                     bus.port_addr_o[0 +: AW]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    function automatic prf_wr_req_t port_view(int k);
        prf_wr_req_t r;
        r.valid = bus.port_valid_o[k];
        r.addr  = bus.port_addr_o[k*AW +: AW];
        r.data  = bus.port_data_o[k*DW +: DW];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.flush_i    = 1'b0;
        bus.wr_valid_i = '0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
    endtask

    task automatic set_ch(int ch, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.wr_valid_i[ch]           = 1'b1;
        bus.wr_addr_i[ch*AW +: AW]   = a;
        bus.wr_data_i[ch*DW +: DW]   = d;
    endtask

    task automatic do_reset();
        drive_idle();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        prf_wr_req_t exp_p;
        drive_idle();
        rstn = 1'b0;
        for (int i = 0; i < NR; i++) set_ch(i, AW'(10 + i), DW'(64'h100 + i));
        #1;
        n_vec++;
        if (bus.port_valid_o !== '0 || bus.port_addr_o !== '0 || bus.port_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_ports: got valid %b addr %0h, required 0",
                     bus.port_valid_o, bus.port_addr_o);
        end
        n_vec++;
        if (bus.pend_cnt_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_pend_cnt: got %0d, required 0", bus.pend_cnt_o);
        end
        n_vec++;
        if (bus.wr_ready_o !== ALL1) begin
            n_err++;
            $display("FAIL reset_ready: got %b, required %b", bus.wr_ready_o, ALL1);
        end
        tick();
        n_vec++;
        if (bus.port_valid_o !== '0 || bus.pend_cnt_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_held_edge: got valid %b cnt %0d, required 0 0",
                     bus.port_valid_o, bus.pend_cnt_o);
        end
        rstn = 1'b1;
        tick();
        n_vec++;
        if (bus.pend_cnt_o !== 3'd7) begin
            n_err++;
            $display("FAIL first_accept_cnt: got %0d, required 7", bus.pend_cnt_o);
        end
        n_vec++;
        if (bus.wr_ready_o !== 7'b0000011) begin
            n_err++;
            $display("FAIL first_accept_ready: got %b, required 0000011", bus.wr_ready_o);
        end
        drive_idle();
        tick();
        for (int k = 0; k < NP; k++) begin
            exp_p = '{valid: 1'b1, addr: AW'(10 + k), data: DW'(64'h100 + k)};
            n_vec++;
            if (port_view(k) !== exp_p) begin
                n_err++;
                $display("FAIL first_grant_port%0d: got %0h, required %0h", k, port_view(k), exp_p);
            end
        end
        n_vec++;
        if (bus.pend_cnt_o !== 3'd5) begin
            n_err++;
            $display("FAIL first_grant_cnt: got %0d, required 5", bus.pend_cnt_o);
        end
    endtask

    task automatic test_two_channels();
        prf_wr_req_t exp_p;
        do_reset();
        set_ch(0, 6'd5, 64'hA);
        set_ch(3, 6'd9, 64'hB);
        #1;
        n_vec++;
        if (bus.wr_ready_o !== ALL1) begin
            n_err++;
            $display("FAIL two_ch_ready0: got %b, required %b", bus.wr_ready_o, ALL1);
        end
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (bus.wr_ready_o !== ALL1 || bus.pend_cnt_o !== 3'd2) begin
            n_err++;
            $display("FAIL two_ch_pending: got ready %b cnt %0d, required %b 2",
                     bus.wr_ready_o, bus.pend_cnt_o, ALL1);
        end
        tick();
        exp_p = '{valid: 1'b1, addr: 6'd5, data: 64'hA};
        n_vec++;
        if (port_view(0) !== exp_p) begin
            n_err++;
            $display("FAIL two_ch_port0: got %0h, required %0h", port_view(0), exp_p);
        end
        exp_p = '{valid: 1'b1, addr: 6'd9, data: 64'hB};
        n_vec++;
        if (port_view(1) !== exp_p) begin
            n_err++;
            $display("FAIL two_ch_port1: got %0h, required %0h", port_view(1), exp_p);
        end
        n_vec++;
        if (dut.rr_ptr_q !== 3'd4) begin
            n_err++;
            $display("FAIL two_ch_rr_ptr: got %0d, required 4", dut.rr_ptr_q);
        end
    endtask

    task automatic test_all_contend();
        int            acc_cnt [NR];
        int            gcnt [NR];
        logic [NR-1:0] m;
        int            ch;
        prf_wr_req_t   exp_p;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            acc_cnt[i] = 0;
            gcnt[i]    = 0;
            set_ch(i, AW'(i), {32'(i), 32'(0)});
        end
        tick();
        for (int i = 0; i < NR; i++) acc_cnt[i] = 1;
        for (int n = 0; n < 10; n++) begin
            m = '0;
            m[(2 * n) % NR]     = 1'b1;
            m[(2 * n + 1) % NR] = 1'b1;
            for (int i = 0; i < NR; i++) bus.wr_data_i[i*DW +: DW] = {32'(i), 32'(acc_cnt[i])};
            #1;
            n_vec++;
            if (bus.wr_ready_o !== m || bus.pend_cnt_o !== 3'd7) begin
                n_err++;
                $display("FAIL contend_ready_r%0d: got ready %b cnt %0d, required %b 7",
                         n, bus.wr_ready_o, bus.pend_cnt_o, m);
            end
            tick();
            for (int i = 0; i < NR; i++) if (m[i]) acc_cnt[i]++;
            for (int k = 0; k < NP; k++) begin
                ch    = (2 * n + k) % NR;
                exp_p = '{valid: 1'b1, addr: AW'(ch), data: {32'(ch), 32'(gcnt[ch])}};
                gcnt[ch]++;
                n_vec++;
                if (port_view(k) !== exp_p) begin
                    n_err++;
                    $display("FAIL contend_port%0d_r%0d: got %0h, required %0h",
                             k, n, port_view(k), exp_p);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        prf_wr_req_t exp_p;
        do_reset();
        set_ch(5, 6'd1, 64'h1);
        tick();
        drive_idle();
        tick();
        n_vec++;
        if (bus.port_valid_o !== 2'b01 || dut.rr_ptr_q !== 3'd6) begin
            n_err++;
            $display("FAIL b2b_setup: got valid %b ptr %0d, required 01 6",
                     bus.port_valid_o, dut.rr_ptr_q);
        end
        for (int j = 0; j < 5; j++) begin
            if (j < 4) set_ch(6, AW'(40 + j), DW'(64'h60 + j));
            else drive_idle();
            #1;
            n_vec++;
            if (bus.wr_ready_o !== ALL1) begin
                n_err++;
                $display("FAIL b2b_ready_%0d: got %b, required %b", j, bus.wr_ready_o, ALL1);
            end
            tick();
            if (j == 0) exp_p = '0;
            else exp_p = '{valid: 1'b1, addr: AW'(40 + j - 1), data: DW'(64'h60 + j - 1)};
            n_vec++;
            if (port_view(0) !== exp_p || bus.port_valid_o[1] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_port_%0d: got %0h valid1 %b, required %0h 0",
                         j, port_view(0), bus.port_valid_o[1], exp_p);
            end
        end
        n_vec++;
        if (dut.rr_ptr_q !== 3'd0) begin
            n_err++;
            $display("FAIL b2b_rr_wrap: got %0d, required 0", dut.rr_ptr_q);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) set_ch(i, AW'(30 + i), DW'(i));
        tick();
        n_vec++;
        if (bus.pend_cnt_o !== 3'd5) begin
            n_err++;
            $display("FAIL flush_pre_cnt: got %0d, required 5", bus.pend_cnt_o);
        end
        bus.flush_i = 1'b1;
        for (int i = 0; i < NR; i++) set_ch(i, AW'(50 + i), DW'(64'h500 + i));
        #1;
        n_vec++;
        if (bus.wr_ready_o !== '0) begin
            n_err++;
            $display("FAIL flush_ready: got %b, required 0000000", bus.wr_ready_o);
        end
        tick();
        bus.flush_i = 1'b0;
        n_vec++;
        if (bus.pend_cnt_o !== 3'd0 || bus.port_valid_o !== '0 ||
            bus.port_addr_o !== '0 || bus.port_data_o !== '0) begin
            n_err++;
            $display("FAIL flush_clear: got cnt %0d valid %b addr %0h, required 0 00 0",
                     bus.pend_cnt_o, bus.port_valid_o, bus.port_addr_o);
        end
        n_vec++;
        if (dut.rr_ptr_q !== 3'd0) begin
            n_err++;
            $display("FAIL flush_rr_hold: got %0d, required 0", dut.rr_ptr_q);
        end
        #1;
        n_vec++;
        if (bus.wr_ready_o !== ALL1) begin
            n_err++;
            $display("FAIL flush_resume_ready: got %b, required %b", bus.wr_ready_o, ALL1);
        end
        tick();
        n_vec++;
        if (bus.pend_cnt_o !== 3'd7) begin
            n_err++;
            $display("FAIL flush_resume_cnt: got %0d, required 7", bus.pend_cnt_o);
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) set_ch(i, AW'(20 + i), DW'(64'h200 + i));
        tick();
        drive_idle();
        tick();
        n_vec++;
        if (bus.port_valid_o !== 2'b11 || bus.pend_cnt_o !== 3'd3) begin
            n_err++;
            $display("FAIL areset_pre: got valid %b cnt %0d, required 11 3",
                     bus.port_valid_o, bus.pend_cnt_o);
        end
        #3;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (bus.port_valid_o !== '0 || bus.port_addr_o !== '0 || bus.port_data_o !== '0 ||
            bus.pend_cnt_o !== 3'd0 || bus.wr_ready_o !== ALL1) begin
            n_err++;
            $display("FAIL areset_immediate: got valid %b cnt %0d ready %b, required 00 0 %b",
                     bus.port_valid_o, bus.pend_cnt_o, bus.wr_ready_o, ALL1);
        end
        tick();
        rstn = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            n_vec++;
            if (bus.port_valid_o !== '0 || bus.pend_cnt_o !== 3'd0) begin
                n_err++;
                $display("FAIL areset_stale_%0d: got valid %b cnt %0d, required 00 0",
                         j, bus.port_valid_o, bus.pend_cnt_o);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        drive_idle();
        test_reset();
        test_two_channels();
        test_all_contend();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prf_write_arbiter.md
Name: prf_write_arbiter

Overview:
Parametrised physical-regfile write-port arbiter. NUM_REQ writeback channels compete for NUM_PORT regfile write ports.
- Each channel has a one-entry pending buffer with a valid/ready handshake, so a request that loses arbitration is held rather than dropped.
- Ports are granted round-robin, and port outputs are registered.
- Sits between the execute/LSU writeback buses and the physical register file in the RCU.

Parameters:
NUM_REQ, 7, number of writeback request channels (2..16)
NUM_PORT, 2, number of regfile write ports (1..NUM_REQ)
REG_ADDR_WIDTH, 6, physical register index width
REG_DATA_WIDTH, 64, register data width
PTR_W, $clog2(NUM_REQ), round-robin pointer width (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous active-low reset
flush_i  input  1  pipeline flush; discards all pending and outgoing writes
wr_valid_i  input  NUM_REQ  per-channel request valid
wr_ready_o  output  NUM_REQ  per-channel ready; a transfer occurs when valid&ready
wr_addr_i  input  NUM_REQ*REG_ADDR_WIDTH  channel i at slice [i*AW +: AW]
wr_data_i  input  NUM_REQ*REG_DATA_WIDTH  channel i at slice [i*DW +: DW]
port_valid_o  output  NUM_PORT  registered write-port enable
port_addr_o  output  NUM_PORT*REG_ADDR_WIDTH  registered write-port address
port_data_o  output  NUM_PORT*REG_DATA_WIDTH  registered write-port data
pend_cnt_o  output  $clog2(NUM_REQ+1)  number of occupied pending buffers (registered)

Behaviour:
State:
- pend_vld[i], pend_addr[i], pend_data[i]
- rr_ptr (PTR_W bits)
- output registers
- pend_cnt

Reset (rstn low, asynchronous): all of the above cleared to 0. All outputs read 0 during reset; wr_ready_o is all-1.

Grant (combinational, each cycle):
- Scan pend_vld cyclically from rr_ptr: rr_ptr, rr_ptr+1, ..., wrapping NUM_REQ-1 -> 0.
- The first min(NUM_PORT, popcount) set entries are granted.
- The k-th granted entry in scan order maps to port k.

Ready:
- wr_ready_o[i] = ~flush_i & (~pend_vld[i] | grant[i]).
- A granted entry may be refilled in the same cycle it drains.

Edge update (no flush):
- Granted entries drive port registers: port_valid_o[k]=1 with addr/data of that entry.
- Unused ports get valid=0 and addr/data forced to 0.
- pend_vld[i] <= (pend_vld[i] & ~grant[i]) | (wr_valid_i[i] & wr_ready_o[i]).
- On accept, addr/data are captured.

Latency and throughput:
- Request presented in cycle c and accepted -> pending in c+1 -> earliest port_valid_o in c+2.
- Sustained throughput per channel: 1 per cycle when uncontended.

rr_ptr:
- If any grant: rr_ptr <= (index of last granted entry + 1) mod NUM_REQ.
- Else unchanged.
- Wrap from NUM_REQ-1 to 0; NUM_REQ need not be a power of 2.

pend_cnt_o: registered popcount of next pend_vld; never exceeds NUM_REQ.

flush_i high at an edge:
- All pend_vld <= 0; port_valid_o <= 0; port addr/data <= 0; pend_cnt <= 0.
- No accepts that cycle (ready=0).
- rr_ptr holds.
- The write already on the port registers during the flush cycle is still presented that cycle.

Simultaneous events:
- Grant and new accept on the same channel in the same cycle: the old entry goes to its port, the new entry is pending.
- Flush overrides accept and grant.

Precondition (renaming guarantees it): no two simultaneously valid port writes target the same address. The bench asserts this; the RTL does not resolve it.

Reset asserted mid-operation: immediate clear of all state; no write escapes after rstn falls.

Decomposition:
Package rcu_prf_pkg:
- PRF_ADDR_WIDTH, PRF_DATA_WIDTH, PRF_WR_PORTS constants
- prf_wr_req_t struct {valid, addr, data}

One sub-module, rr_multi_pick:
- Combinational; parameters N, K.
- Inputs: req vector, start pointer.
- Outputs: grant vector, K one-hot selects (one per port), last-grant index, any-grant.
- Contains the cyclic scan, implemented as the request vector doubled and priority-picked K times.

Top level holds the pending buffers, port registers, pointer and counter.

Test Plan:
1. Reset with all 7 requests valid -> all outputs 0 and ready all-1 while rstn=0. First edge after release accepts all 7; pend_cnt_o=7 next cycle.
2. Channels 0 and 3 valid once (addr 5 data 0xA, addr 9 data 0xB), rr_ptr=0, issued cycle c -> cycle c+2: port0={5,0xA}, port1={9,0xB}; rr_ptr=4; ready stays 1.
3. All 7 channels valid every cycle, NUM_PORT=2 -> grants rotate {0,1},{2,3},{4,5},{6,0},{1,2}... Each channel's ready is low while its entry waits. No request lost; each channel is serviced within ceil(7/2)=4 grant cycles.
4. Channel 6 only, rr_ptr=6, back-to-back requests for 4 cycles -> port0 valid for 4 consecutive cycles (c+2..c+5); ready never drops; rr_ptr ends at 0 (wrap).
5. Five pending entries, then flush_i pulsed one cycle with wr_valid_i=all-1 -> ready=0 that cycle; next cycle pend_cnt_o=0 and port_valid_o=0; rr_ptr unchanged; accepts resume the following cycle.
6. rstn dropped asynchronously mid-cycle with 3 pending and port_valid_o=2'b11 -> all outputs read 0 immediately, before the next clock edge; after release no stale write appears.
